// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order fetch requests and queues
// returned instructions (with their PCs) toward decode. Flushes drop in-flight responses.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_inst,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  input  logic            out_ready
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam int unsigned     PW       = AW + 1;
  localparam int unsigned     DW       = AW + 2;
  localparam logic [PW-1:0]   DepthCnt = PW'(DEPTH);
  localparam logic [XLEN-1:0] PcStep   = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_alloc;
  logic [PW-1:0]   r_fill;
  logic [DW-1:0]   r_drop;
  logic [XLEN-1:0] r_pc_q   [DEPTH];
  logic [XLEN-1:0] r_inst_q [DEPTH];

  logic            w_accept;
  logic            w_resp_keep;
  logic            w_resp_drop;
  logic            w_pop;
  logic            w_flush;
  logic [PW-1:0]   w_used;
  logic [PW-1:0]   w_head_nxt;
  logic [PW-1:0]   w_alloc_nxt;
  logic [PW-1:0]   w_fill_nxt;
  logic [PW-1:0]   w_inflight;
  logic [DW-1:0]   w_drop_nxt;
  logic [XLEN-1:0] w_pc_nxt;

  // Occupancy counts allocated entries, whether or not their response has arrived.
  assign w_used        = r_alloc - r_head;
  assign mem_req_valid = ~RST & (w_used < DepthCnt);
  assign mem_req_addr  = r_pc;

  assign w_accept    = mem_req_valid & mem_req_ready;
  assign w_resp_drop = mem_resp_valid & (r_drop != '0);
  assign w_resp_keep = mem_resp_valid & (r_drop == '0);
  assign w_flush     = trap_valid | redirect_valid;

  assign out_valid = (r_fill != r_head);
  assign w_pop     = out_valid & out_ready;
  // Empty head reads as zero so stale storage never leaks onto the decode port.
  assign out_pc    = out_valid ? r_pc_q[r_head[AW-1:0]]   : '0;
  assign out_inst  = out_valid ? r_inst_q[r_head[AW-1:0]] : '0;

  assign w_alloc_nxt = r_alloc + PW'(w_accept);
  assign w_fill_nxt  = r_fill + PW'(w_resp_keep);
  assign w_head_nxt  = r_head + PW'(w_pop);
  assign w_inflight  = w_alloc_nxt - w_fill_nxt;

  always_comb begin
    w_drop_nxt = r_drop - DW'(w_resp_drop);
    w_pc_nxt   = w_accept ? (r_pc + PcStep) : r_pc;
    if (w_flush) begin
      // Requests still outstanding after this edge belong to the discarded stream.
      w_drop_nxt = w_drop_nxt + {1'b0, w_inflight};
      w_pc_nxt   = trap_valid ? trap_addr : redirect_addr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
      r_drop  <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_drop <= w_drop_nxt;
      if (w_flush) begin
        r_head  <= '0;
        r_alloc <= '0;
        r_fill  <= '0;
      end else begin
        r_head  <= w_head_nxt;
        r_alloc <= w_alloc_nxt;
        r_fill  <= w_fill_nxt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_pc_q[r_alloc[AW-1:0]] <= r_pc;
    end
    if (w_resp_keep) begin
      r_inst_q[r_fill[AW-1:0]] <= mem_resp_inst;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency, a
// stream-level reference model of the expected PC sequence, directed vectors and random traffic.
module tb_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(RPC),
    .DEPTH   (DEPTH)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .trap_valid    (trap_valid),
    .trap_addr     (trap_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_inst (mem_resp_inst),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_ready     (out_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    bit          tv;
    logic [31:0] ta;
    bit          rv;
    logic [31:0] ra;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } flush_vec_t;

  req_t        pend[$];   // memory: accepted requests awaiting response
  logic [31:0] exp_q[$];  // reference: PCs owed to decode since the last flush
  logic [31:0] pc_m;
  int          ready_cnt;
  int          epoch;
  int          cyc;
  int          last_due;
  int          dut_acc;
  int          chk_cnt;
  int          pass_cnt;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic drive_idle();
    mem_req_ready  = 1'b0;
    out_ready      = 1'b0;
    trap_valid     = 1'b0;
    trap_addr      = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    mem_resp_valid = 1'b0;
    mem_resp_inst  = '0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the reference across the edge.
  task automatic step(input bit rdy, input bit ordy, input bit tv, input logic [31:0] ta,
                      input bit rv, input logic [31:0] ra, input int lat);
    bit   exp_rv;
    bit   exp_ov;
    bit   resp;
    req_t e;
    exp_rv = exp_q.size() < DEPTH;
    exp_ov = ready_cnt > 0;
    chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
    chk("req_addr", mem_req_addr, pc_m);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", out_pc, exp_q[0]);
      chk("out_inst", out_inst, inst_of(exp_q[0]));
    end
    if (mem_req_valid && rdy) dut_acc++;
    mem_req_ready  = rdy;
    out_ready      = ordy;
    trap_valid     = tv;
    trap_addr      = ta;
    redirect_valid = rv;
    redirect_addr  = ra;
    resp           = (pend.size() > 0) && (pend[0].due <= cyc);
    mem_resp_valid = resp;
    mem_resp_inst  = resp ? inst_of(pend[0].addr) : 32'h0BAD_0BAD;
    if (exp_ov && ordy) begin
      void'(exp_q.pop_front());
      ready_cnt--;
    end
    if (resp) begin
      e = pend.pop_front();
      if (e.epoch == epoch) ready_cnt++;
    end
    if (exp_rv && rdy) begin
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      e.addr   = pc_m;
      e.epoch  = epoch;
      e.due    = last_due;
      pend.push_back(e);
      exp_q.push_back(pc_m);
      pc_m = pc_m + 32'd4;
    end
    if (tv || rv) begin
      exp_q.delete();
      ready_cnt = 0;
      epoch++;
      pc_m = tv ? ta : ra;
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic run(input int n, input bit rdy, input bit ordy, input int lat);
    for (int i = 0; i < n; i++) step(rdy, ordy, 1'b0, '0, 1'b0, '0, lat);
  endtask

  // Asserts RST mid-cycle (asynchronously); memory model is reset alongside.
  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    drive_idle();
    pend.delete();
    exp_q.delete();
    ready_cnt = 0;
    epoch++;
    pc_m      = RPC;
    last_due  = -1;
    dut_acc   = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp_pc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1);
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
    if (found) chk({name, "_pc"}, out_pc, exp_pc);
  endtask

  flush_vec_t fv[4];

  initial begin
    int n;
    chk_cnt   = 0;
    pass_cnt  = 0;
    cyc       = 0;
    epoch     = 0;
    RST       = 1'b1;
    drive_idle();
    fv[0] = '{tv: 1'b1, ta: 32'h0000_0080, rv: 1'b1, ra: 32'h0000_2000,
              exp_addr: 32'h0000_0080, exp_next: 32'h0000_0084};
    fv[1] = '{tv: 1'b0, ta: 32'h0000_0000, rv: 1'b1, ra: 32'h0000_2000,
              exp_addr: 32'h0000_2000, exp_next: 32'h0000_2004};
    fv[2] = '{tv: 1'b1, ta: 32'h0000_0300, rv: 1'b0, ra: 32'h0000_0000,
              exp_addr: 32'h0000_0300, exp_next: 32'h0000_0304};
    fv[3] = '{tv: 1'b0, ta: 32'h0000_0000, rv: 1'b1, ra: 32'hFFFF_FFFC,
              exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
    @(negedge CLK);
    do_reset();

    // Full-rate streaming from RESET_PC.
    chk("tp_first_addr", mem_req_addr, RPC);
    run(2, 1'b1, 1'b1, 1);
    chk("tp_first_valid", 32'(out_valid), 32'd1);
    chk("tp_first_pc", out_pc, RPC);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) n++;
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1);
    end
    chk("tp_rate", n, 8);

    // Decode stalled: queue fills after exactly DEPTH accepts.
    do_reset();
    run(10, 1'b1, 1'b0, 1);
    chk("stall_accepts", dut_acc, 4);
    chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
    chk("stall_pc", mem_req_addr, 32'h0000_0110);
    run(6, 1'b1, 1'b1, 1);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    run(2, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0000_2000, 3);
    wait_out("redir", 32'h0000_2000);

    // Back-to-back redirects: the later target wins.
    do_reset();
    run(3, 1'b1, 1'b1, 3);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h0000_3000, 3);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h0000_4000, 3);
    wait_out("b2b", 32'h0000_4000);

    // Table of flush vectors, including trap priority and PC wrap.
    for (int i = 0; i < 4; i++) begin
      run(3, 1'b1, 1'b1, 2);
      step(1'b1, 1'b1, fv[i].tv, fv[i].ta, fv[i].rv, fv[i].ra, 2);
      chk("flush_req_valid", 32'(mem_req_valid), 32'd1);
      chk("flush_addr", mem_req_addr, fv[i].exp_addr);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1);
      chk("flush_next_addr", mem_req_addr, fv[i].exp_next);
    end

    // Reset mid-stream with entries queued and requests in flight.
    run(6, 1'b1, 1'b0, 3);
    do_reset();
    chk("midrst_addr", mem_req_addr, RPC);
    run(12, 1'b1, 1'b1, 2);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit          tv;
      bit          rv;
      logic [31:0] ta;
      logic [31:0] ra;
      tv = ($urandom_range(0, 79) == 0);
      rv = ($urandom_range(0, 29) == 0);
      ta = $urandom & 32'hFFFF_FFFC;
      ra = $urandom & 32'hFFFF_FFFC;
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0),
           tv, ta, rv, ra, int'($urandom_range(1, 4)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RISC-V core. It holds the program counter, issues in-order fetch requests to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue toward decode under a valid/ready handshake. On a branch/jump redirect or trap it flushes the queue and silently discards responses for requests that were already in flight.

## Interface
- XLEN, 32: address/instruction width.
- RESET_PC, 0: PC value after reset.
- DEPTH, 4: fetch-queue entries; power of 2, ≥2.

- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken; load redirect_addr.
- redirect_addr  in  XLEN  redirect target.
- trap_valid  in  1  exception/interrupt; priority over redirect.
- trap_addr  in  XLEN  trap vector.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  XLEN  fetch address (= PC).
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_resp_valid  in  1  in-order response valid.
- mem_resp_inst  in  XLEN  fetched instruction.
- out_valid  out  1  head queue entry filled.
- out_pc  out  XLEN  PC of head entry.
- out_inst  out  XLEN  instruction of head entry.
- out_ready  in  1  decode consumes head entry.

## Operation
- Queue: circular buffer, three pointers (head, alloc, fill), each log2(DEPTH)+1 bits with wrap bit. Entry allocated on request accept (stores PC), filled on response (stores inst), freed on pop.
- Request: mem_req_valid = (alloc − head) < DEPTH; mem_req_addr = PC. Accept = mem_req_valid & mem_req_ready → PC <= PC + 4 (mod 2^XLEN), alloc++.
- Response: if drop_cnt > 0, discard and drop_cnt−−; else write mem_resp_inst at fill, fill++. Memory guarantees in-order responses, at least 1 cycle after accept.
- Output: out_valid = (fill ≠ head); out_pc/out_inst from head. Pop = out_valid & out_ready → head++.
- Flush (trap_valid | redirect_valid), effective at the clock edge: PC <= trap_valid ? trap_addr : redirect_addr; head = alloc = fill = 0; drop_cnt <= drop_cnt + (alloc − fill) + (accept this cycle) − (non-dropped response this cycle counted already in alloc−fill, i.e. use post-update in-flight count). Pop, accept and response in the flush cycle complete normally before the flush.
- drop_cnt width log2(DEPTH)+2; never exceeds 2·DEPTH.
- Stall: no request when queue+in-flight = DEPTH; PC holds; mem_req_addr stable until accepted or flushed (flush may withdraw a pending request).

## Timing
- Reset (async): PC = RESET_PC, pointers = 0, drop_cnt = 0; mem_req_valid = 1 only after RST deasserts; out_valid = 0, out_pc = 0, out_inst = 0 (empty entries read as 0).
- First cycle after reset: mem_req_valid = 1, mem_req_addr = RESET_PC.
- Latency: response at edge N → out_valid high in cycle N+1 (registered fill).
- Flush asserted in cycle N → cycle N+1: out_valid = 0, mem_req_valid = 1, mem_req_addr = target; responses for pre-flush requests never appear on out_*.
- Back-to-back flushes: each flush adds its in-flight count to drop_cnt; last flush's target wins.
- Throughput: 1 instruction/cycle with mem_req_ready = 1, 1-cycle memory, out_ready = 1.

## Test plan
- Reset, RESET_PC = 0x100, 1-cycle memory, out_ready = 1 → requests 0x100, 0x104, 0x108…; out_pc 0x100 first at cycle 2, one per cycle after.
- out_ready = 0, DEPTH = 4 → exactly 4 requests accepted, mem_req_valid = 0, PC = 0x110; raising out_ready resumes with 0x110.
- 3-cycle memory latency, 2 requests in flight, redirect to 0x2000 → both stale responses dropped; next out_pc = 0x2000.
- trap_valid (0x80) and redirect_valid (0x2000) same cycle → PC = 0x80, queue empty next cycle.
- PC = 0xFFFFFFFC, accept → next mem_req_addr = 0x00000000.
- Assert RST mid-stream with entries queued and requests in flight → out_valid = 0 immediately, mem_req_addr = RESET_PC after release, no stale response forwarded (memory also reset).
